// File: rtl/byte_encode_pkg.sv
// Shared Kyber constants and helpers for the ByteEncode_d packer.
// Coefficient widths and per-polynomial byte counts are derived here.
package byte_encode_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;

  // 256 coefficients of d bits each always fill a whole number of bytes.
  function automatic int bytes_per_poly(input int d);
    return (KYBER_N * d) / 8;
  endfunction

  function automatic bit d_is_legal(input int d);
    return (d == 1) || (d == 4) || (d == 5) || (d == 10) || (d == 11) || (d == 12);
  endfunction

endpackage

// File: rtl/byte_encode_compress.sv
// Kyber Compress_d: y = round(2^D * x / q) mod 2^D for x in [0, q-1].
// Purely combinational; used only by the fused-compress build of byte_encode.
module byte_encode_compress
  import byte_encode_pkg::*;
#(
  parameter int D = 1
) (
  input  logic [11:0]  x,
  output logic [D-1:0] y
);

  localparam int W = 12 + D + 1;

  logic [W-1:0] num;

  // Adding floor(q/2) before the divide turns truncation into round-half-up.
  assign num = (W'(x) << D) + W'(KYBER_Q / 2);
  assign y   = D'(num / W'(KYBER_Q));

endmodule

// File: rtl/byte_encode.sv
// Streaming ByteEncode_d packer: one D-bit coefficient in, little-endian bytes out.
// Define BYTE_ENCODE_FUSED_COMPRESS_EN to take 12-bit coefficients and compress them inline.
module byte_encode
  import byte_encode_pkg::*;
#(
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef BYTE_ENCODE_FUSED_COMPRESS_EN
  input  logic [11:0]  in_data,
`else
  input  logic [D-1:0] in_data,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  localparam int AW = D + 7;
  localparam int NB = bytes_per_poly(D);

  generate
    if (!d_is_legal(D)) begin : g_illegal_d
      $error("byte_encode: D=%0d is not one of 1, 4, 5, 10, 11, 12", D);
    end
`ifdef BYTE_ENCODE_FUSED_COMPRESS_EN
    if (D == 12) begin : g_illegal_fused_d
      $error("byte_encode: D=12 cannot be combined with fused compression");
    end
`endif
  endgenerate

  logic [AW-1:0] acc_reg, acc_next;
  logic [4:0]    cnt_reg, cnt_next;
  logic [7:0]    coef_cnt_reg, coef_cnt_next;
  logic [8:0]    byte_cnt_reg, byte_cnt_next;
  logic [D-1:0]  coef;
  logic          accept;
  logic          fire;
  logic          last_byte;

`ifdef BYTE_ENCODE_FUSED_COMPRESS_EN
  byte_encode_compress #(.D(D)) u_compress (
    .x (in_data),
    .y (coef)
  );
`else
  assign coef = in_data;
`endif

  // Every output decodes from registered state; only in_ready also sees rst.
  assign in_ready  = ~rst & (cnt_reg < 5'd8);
  assign out_valid = (cnt_reg >= 5'd8);
  assign out_byte  = acc_reg[7:0];
  assign last_byte = (byte_cnt_reg == 9'(NB - 1));
  assign out_last  = out_valid & last_byte;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  // accept needs cnt < 8 and fire needs cnt >= 8, so at most one happens per cycle.
  always_comb begin
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    coef_cnt_next = coef_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    if (accept) begin
      acc_next      = acc_reg | (AW'(coef) << cnt_reg);
      cnt_next      = cnt_reg + 5'(D);
      coef_cnt_next = coef_cnt_reg + 8'd1;
    end else if (fire) begin
      acc_next      = acc_reg >> 8;
      cnt_next      = cnt_reg - 5'd8;
      byte_cnt_next = last_byte ? 9'd0 : byte_cnt_reg + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      coef_cnt_reg <= '0;
      byte_cnt_reg <= '0;
    end else begin
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      coef_cnt_reg <= coef_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
    end
  end

  // The final byte of a polynomial can only exist once all 256 coefficients are in.
  a_last_after_full_poly : assert property (
    @(posedge clk) disable iff (rst) (out_last && out_ready) |-> (coef_cnt_reg == 8'd0)
  );

endmodule

// File: tb/tb_byte_encode.sv
// Directed self-checking bench for byte_encode across several D instances.
// With BYTE_ENCODE_FUSED_COMPRESS_EN defined only the fused D=1 instance is exercised.
module tb_byte_encode;

`ifdef BYTE_ENCODE_FUSED_COMPRESS_EN
  localparam int NI = 1;
  localparam int DS [NI] = '{1};
`else
  localparam int NI = 5;
  localparam int DS [NI] = '{1, 4, 10, 12, 11};
`endif
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic          ordy = 1'b0;
  logic [11:0]   din = '0;
  int            sel = 0;

  logic [NI-1:0] iv, ir, ov_a, orr, ol;
  logic [7:0]    ob [NI];
  logic          irdy, ov, olast;
  logic [7:0]    obyte;

  int            n_tests = 0;
  int            n_fail = 0;
  int            byte_k = 0;
  int            bpp = 32;
  logic [11:0]   coefs [$];
  logic [7:0]    exp_q [$];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      assign iv[gi]  = vld & (sel == gi);
      assign orr[gi] = ordy & (sel == gi);
      byte_encode #(.D(DS[gi])) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef BYTE_ENCODE_FUSED_COMPRESS_EN
        .in_data   (din),
`else
        .in_data   (din[DS[gi]-1:0]),
`endif
        .in_valid  (iv[gi]),
        .in_ready  (ir[gi]),
        .out_byte  (ob[gi]),
        .out_valid (ov_a[gi]),
        .out_ready (orr[gi]),
        .out_last  (ol[gi])
      );
    end
  endgenerate

  assign irdy  = ir[sel];
  assign ov    = ov_a[sel];
  assign olast = ol[sel];
  assign obyte = ob[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic select(input int i);
    sel = i;
    bpp = 32 * DS[i];
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; vld = 1'b0; ordy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    byte_k = 0;
  endtask

  // Reference packer: walks the stream bit by bit, LSB of each coefficient first.
  function automatic void build_exp(input int d);
    logic [7:0] cur;
    int bp;
    cur = '0;
    bp = 0;
    exp_q.delete();
    foreach (coefs[i]) begin
      for (int j = 0; j < d; j++) begin
        cur[bp] = coefs[i][j];
        bp++;
        if (bp == 8) begin
          exp_q.push_back(cur);
          cur = '0;
          bp = 0;
        end
      end
    end
  endfunction

  // Feeds coefs, drains bytes against exp_q; checks hold-stability on every stall.
  task automatic run_stream(input string name, input bit rand_rdy, output int got);
    int idx;
    int cyc;
    bit stalled;
    logic [7:0] prev_b;
    logic prev_l;
    idx = 0; cyc = 0; got = 0; stalled = 1'b0; prev_b = '0; prev_l = 1'b0;
    while ((idx < coefs.size() || got < exp_q.size()) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check({name, "_hold_byte"}, 32'(obyte), 32'(prev_b));
        check({name, "_hold_last"}, 32'(olast), 32'(prev_l));
        check({name, "_hold_in_ready"}, 32'(irdy), 32'(0));
      end
      ordy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      stalled = 1'b0;
      if (ov) begin
        if (ordy) begin
          if (got < exp_q.size())
            check({name, "_byte"}, 32'(obyte), 32'(exp_q[got]));
          else
            check({name, "_byte_count"}, 32'(got + 1), 32'(exp_q.size()));
          check({name, "_last"}, 32'(olast), 32'(((byte_k + 1) % bpp) == 0));
          got++;
          byte_k++;
        end else begin
          stalled = 1'b1;
          prev_b = obyte;
          prev_l = olast;
        end
      end
      if (irdy && idx < coefs.size()) begin
        vld = 1'b1;
        din = coefs[idx];
        idx++;
      end else begin
        vld = 1'b0;
      end
    end
    @(negedge clk);
    vld = 1'b0;
    ordy = 1'b0;
    check({name, "_coefs_sent"}, 32'(idx), 32'(coefs.size()));
    check({name, "_bytes_seen"}, 32'(got), 32'(exp_q.size()));
    check({name, "_idle_after"}, 32'(ov), 32'(0));
    $display("[TB] stream %s: %0d coefficients, %0d bytes", name, idx, got);
  endtask

  initial begin
    int got;

    // Reset state of every instance
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      select(i);
      check("in_ready_during_rst", 32'(irdy), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      select(i);
      check("rst_out_valid", 32'(ov), 32'(0));
      check("rst_out_last", 32'(olast), 32'(0));
      check("rst_out_byte", 32'(obyte), 32'(0));
      check("rst_in_ready", 32'(irdy), 32'(1));
    end

`ifdef BYTE_ENCODE_FUSED_COMPRESS_EN
    select(0);
    pulse_reset();
    coefs = '{12'd1665, 12'd832, 12'd832, 12'd832, 12'd832, 12'd832, 12'd832, 12'd832};
    exp_q = '{8'h01};
    run_stream("fused_1665", 1'b0, got);
    pulse_reset();
    coefs = '{12'd832, 12'd1665, 12'd1665, 12'd1665, 12'd1665, 12'd1665, 12'd1665, 12'd1665};
    exp_q = '{8'hFE};
    run_stream("fused_832", 1'b0, got);
    pulse_reset();
    coefs = '{12'd1665, 12'd832, 12'd1665, 12'd832, 12'd1665, 12'd832, 12'd1665, 12'd832};
    exp_q = '{8'h55};
    run_stream("fused_alt", 1'b1, got);
`else
    // D=1: eight bits, byte appears the cycle after the eighth accept
    begin
      logic [7:0] bits;
      select(0);
      pulse_reset();
      bits = 8'b1000_1101;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check("d1_no_byte_yet", 32'(ov), 32'(0));
        check("d1_in_ready", 32'(irdy), 32'(1));
        vld = 1'b1;
        din = {11'd0, bits[i]};
      end
      @(negedge clk);
      vld = 1'b0;
      check("d1_valid_after_8th", 32'(ov), 32'(1));
      check("d1_byte", 32'(obyte), 32'h8D);
      check("d1_last", 32'(olast), 32'(0));
      check("d1_in_ready_blocked", 32'(irdy), 32'(0));
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      check("d1_drained", 32'(ov), 32'(0));
      check("d1_in_ready_back", 32'(irdy), 32'(1));
      $display("[TB] d1 directed byte 0x8D");
    end

    // D=4 and D=10 short directed vectors
    select(1);
    pulse_reset();
    coefs = '{12'h3, 12'hA};
    exp_q = '{8'hA3};
    run_stream("d4", 1'b0, got);

    select(2);
    pulse_reset();
    coefs = '{12'h3FF, 12'h001};
    exp_q = '{8'hFF, 8'h07};
    run_stream("d10", 1'b0, got);
    check("d10_pending_ready", 32'(irdy), 32'(1));

    // D=12 directed vector, then a full polynomial under random backpressure
    select(3);
    pulse_reset();
    coefs = '{12'hABC, 12'hABC};
    exp_q = '{8'hBC, 8'hCA, 8'hAB};
    run_stream("d12", 1'b0, got);

    pulse_reset();
    coefs.delete();
    for (int i = 0; i < 256; i++) coefs.push_back(12'($urandom_range(0, 4095)));
    build_exp(12);
    run_stream("d12_poly", 1'b1, got);
    check("d12_poly_bytes", 32'(got), 32'd384);

    // Explicit 5-cycle stall on a pending byte
    pulse_reset();
    @(negedge clk);
    vld = 1'b1;
    din = 12'hABC;
    @(negedge clk);
    vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(ov), 32'(1));
      check("bp_byte", 32'(obyte), 32'hBC);
      check("bp_last", 32'(olast), 32'(0));
      check("bp_in_ready", 32'(irdy), 32'(0));
      @(negedge clk);
    end
    coefs = '{12'hABC};
    exp_q = '{8'hBC, 8'hCA, 8'hAB};
    run_stream("d12_bp", 1'b0, got);

    // D=11: three back-to-back polynomials with random out_ready
    select(4);
    pulse_reset();
    coefs.delete();
    for (int i = 0; i < 768; i++) coefs.push_back(12'($urandom_range(0, 2047)));
    build_exp(11);
    run_stream("d11_3poly", 1'b1, got);
    check("d11_3poly_bytes", 32'(got), 32'd1056);

    // Reset after 100 coefficients with a byte pending
    pulse_reset();
    coefs.delete();
    for (int i = 0; i < 100; i++) coefs.push_back(12'($urandom_range(0, 2047)));
    build_exp(11);
    run_stream("d11_part", 1'b0, got);
    @(negedge clk);
    vld = 1'b1;
    din = 12'h7FF;
    @(negedge clk);
    vld = 1'b0;
    check("mid_pending", 32'(ov), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(ov), 32'(0));
    check("mid_rst_byte", 32'(obyte), 32'(0));
    check("mid_rst_last", 32'(olast), 32'(0));
    check("mid_rst_in_ready", 32'(irdy), 32'(0));
    rst = 1'b0;
    byte_k = 0;
    #1;
    check("mid_rst_ready_back", 32'(irdy), 32'(1));
    coefs.delete();
    for (int i = 0; i < 256; i++) coefs.push_back(12'($urandom_range(0, 2047)));
    build_exp(11);
    run_stream("d11_after_rst", 1'b1, got);
    check("d11_after_rst_bytes", 32'(got), 32'd352);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
